// File: rtl/mem_request_unit.sv
// Memory request unit: turns control-unit memory enables and cache hits into
// icache/dcache requests, PC-advance and stall. Optional watchdog: MEM_REQ_WDOG_EN.
module mem_request_unit #(
   parameter int WDOG_CYCLES = 1024
) (
   input  logic CLK,
   input  logic nRST,
   input  logic icuREN,
   input  logic dcuREN,
   input  logic dcuWEN,
   input  logic halt,
   input  logic ihit,
   input  logic dhit,
   output logic imemREN,
   output logic dmemREN,
   output logic dmemWEN,
   output logic pcEN,
   output logic stall,
   output logic halted,
   output logic wdog_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DREQ   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;
   logic   r_dren;
   logic   r_dwen;
   logic   r_halt_pend;
   logic   w_dren_next;
   logic   w_dwen_next;
   logic   w_halt_pend_next;
   logic   w_imem;
   logic   w_pc;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state     <= IDLE;
         r_dren      <= 1'b0;
         r_dwen      <= 1'b0;
         r_halt_pend <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_dren      <= w_dren_next;
         r_dwen      <= w_dwen_next;
         r_halt_pend <= w_halt_pend_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_dren_next      = r_dren;
      w_dwen_next      = r_dwen;
      w_halt_pend_next = r_halt_pend;
      w_imem           = 1'b0;
      w_pc             = 1'b0;
      case (r_state)
         IDLE: begin
            w_imem           = icuREN;
            w_dren_next      = 1'b0;
            w_dwen_next      = 1'b0;
            w_halt_pend_next = 1'b0;
            if (ihit) begin
               // a write wins over a simultaneous read; halt waits for the data op
               if (dcuWEN) begin
                  w_dwen_next      = 1'b1;
                  w_halt_pend_next = halt;
                  w_state_next     = DREQ;
               end else if (dcuREN) begin
                  w_dren_next      = 1'b1;
                  w_halt_pend_next = halt;
                  w_state_next     = DREQ;
               end else if (halt) begin
                  w_state_next = HALTED;
               end else begin
                  w_pc = 1'b1;
               end
            end
         end
         DREQ: begin
            if (dhit) begin
               w_dren_next      = 1'b0;
               w_dwen_next      = 1'b0;
               w_halt_pend_next = 1'b0;
               if (r_halt_pend) begin
                  w_state_next = HALTED;
               end else begin
                  w_state_next = IDLE;
                  w_pc         = 1'b1;
               end
            end
         end
         HALTED: begin
            w_state_next = HALTED;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign imemREN = w_imem;
   assign dmemREN = r_dren;
   assign dmemWEN = r_dwen;
   assign pcEN    = w_pc & nRST;
   assign halted  = (r_state == HALTED);
   assign stall   = !pcEN & !halted;

`ifdef MEM_REQ_WDOG_EN
   localparam int CW = $clog2(WDOG_CYCLES) + 1;
   localparam logic [CW-1:0] W_LIMIT = CW'(WDOG_CYCLES);
   localparam logic [CW-1:0] W_ONE   = CW'(1);

   logic [CW-1:0] r_wdog_cnt;
   logic          r_wdog_err;

   // count saturates at the limit so a long-stuck request never wraps
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_wdog_cnt <= '0;
         r_wdog_err <= 1'b0;
      end else if (r_state == IDLE && w_state_next == DREQ) begin
         r_wdog_cnt <= '0;
      end else if (r_state == DREQ && !dhit && r_wdog_cnt != W_LIMIT) begin
         r_wdog_cnt <= r_wdog_cnt + W_ONE;
         if (r_wdog_cnt + W_ONE == W_LIMIT) begin
            r_wdog_err <= 1'b1;
         end
      end
   end

   assign wdog_err = r_wdog_err;
`else
   // parameter still referenced so both builds share one interface cleanly
   localparam logic W_TIE = (WDOG_CYCLES > 0) ? 1'b0 : 1'b0;
   assign wdog_err = W_TIE;
`endif

endmodule

// File: doc/mem_request_unit.md
# mem_request_unit

Memory request unit for the pipelined MIPS core. It consumes the control unit's memory-enable and halt outputs (`icuREN`, `dcuREN`, `dcuWEN`, `halt`) and the cache hit strobes. It turns them into well-formed instruction and data requests toward the caches, plus PC-advance and stall qualifiers for the datapath. It also owns the sticky halted state.

## Interface
- `WDOG_CYCLES`, default 1024: cycles a data request may stay outstanding before `wdog_err` is set. Only used with the watchdog compiled in.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  reset, synchronous and active-low.
- `icuREN`  in  1  control unit instruction-read enable.
- `dcuREN`  in  1  control unit data-read enable for the current instruction.
- `dcuWEN`  in  1  control unit data-write enable for the current instruction.
- `halt`  in  1  control unit halt decode for the current instruction.
- `ihit`  in  1  instruction cache hit strobe (one cycle).
- `dhit`  in  1  data cache hit strobe (one cycle).
- `imemREN`  out  1  instruction read request to the icache.
- `dmemREN`  out  1  data read request to the dcache (registered).
- `dmemWEN`  out  1  data write request to the dcache (registered).
- `pcEN`  out  1  PC/pipeline advance qualifier.
- `stall`  out  1  datapath hold; equals `!pcEN` while not halted.
- `halted`  out  1  sticky halt indication.
- `wdog_err`  out  1  sticky watchdog timeout flag.

## Operation
- States are IDLE, DREQ and HALTED.
- **IDLE**
  - `imemREN = icuREN`.
  - `dmemREN` and `dmemWEN` are low.
  - On `ihit` with `dcuWEN`: latch `dmemWEN=1` and go to DREQ; `pcEN=0`.
  - On `ihit` with `dcuREN` only: latch `dmemREN=1` and go to DREQ; `pcEN=0`.
  - `dcuWEN` and `dcuREN` both high: treated as a write. The read is dropped and `dmemREN` stays 0.
  - On `ihit` with `halt` and no data op: go to HALTED; `pcEN=0`.
  - On `ihit` with none of the above: `pcEN=1`.
  - `dhit` in IDLE is ignored.
- **DREQ**
  - `imemREN=0`.
  - `dmemREN` and `dmemWEN` hold their latched values.
  - `ihit` is ignored.
  - On `dhit`: `pcEN=1` that cycle, both data enables clear at the next edge, and state returns to IDLE.
  - If `halt` was latched together with the data op, the data op completes first. On `dhit` the state goes to HALTED and `pcEN=0`.
- **HALTED**
  - `imemREN`, `dmemREN`, `dmemWEN` and `pcEN` are all 0.
  - `halted=1`.
  - Only `nRST` leaves this state.
- `stall = !pcEN & !halted`.
- Reset values, applied at the first rising edge with `nRST` low:
  - state IDLE;
  - `dmemREN=0`, `dmemWEN=0`, `halted=0`, `wdog_err=0`, watchdog count 0;
  - `pcEN=0`;
  - `imemREN` follows `icuREN` from IDLE.
- Reset mid-operation: an outstanding data request is abandoned with no completion pulse.

## Timing
- Instruction with no data op: `pcEN` in the same cycle as `ihit`; zero added latency.
- Load/store:
  - `ihit` in cycle N.
  - `dmemREN` or `dmemWEN` high from cycle N+1.
  - `dhit` in cycle M ≥ N+1 gives `pcEN=1` in cycle M.
  - Enables low from cycle M+1.
- Back-to-back: the next instruction fetch (`imemREN`) resumes in cycle M+1.
- Halt: `ihit` with `halt` in cycle N gives `halted=1` and `imemREN=0` from cycle N+1 onward.
- Outputs change only on the rising edge of `CLK`, except `imemREN`, `pcEN` and `stall`. Those three are combinational from the current state and inputs.

## Configuration
- **`MEM_REQ_WDOG_EN` defined:**
  - A counter of width `$clog2(WDOG_CYCLES)+1` clears on entry to DREQ.
  - It increments each DREQ cycle without `dhit`.
  - When the count reaches `WDOG_CYCLES`, `wdog_err` sets and stays set until reset.
  - Request behaviour is unaffected; the request stays asserted.
- **Not defined:** the counter is absent and `wdog_err` is tied to 0.

## Test plan
- **Reset:** hold `nRST=0` two cycles with `icuREN=1`, `dcuWEN=1`, `ihit=1` -> `dmemREN=0`, `dmemWEN=0`, `halted=0`, `wdog_err=0` after the reset edge; state IDLE.
- **ALU stream:** `icuREN=1`, `ihit=1` for 4 cycles with no data op -> `pcEN=1` each cycle, `dmem*` stay 0.
- **Load:**
  - Stimulus: `ihit` with `dcuREN=1` at cycle 5, `dhit` at cycle 9.
  - Response: `dmemREN=1` in cycles 6–9, `pcEN=0` in cycles 5–8, `pcEN=1` in cycle 9, `dmemREN=0` in cycle 10, `imemREN=0` in cycles 6–9.
- **Simultaneous enables and stray hits:**
  - `dcuREN=1` and `dcuWEN=1` on `ihit` -> only `dmemWEN=1`.
  - A `dhit` pulse in IDLE -> no output change.
- **Halt:** `ihit` with `halt=1` at cycle 3, then `ihit`/`dhit` toggled for 10 cycles -> `halted=1` from cycle 4, all enables 0, `pcEN=0` until `nRST` is pulsed.
- **Watchdog:** built with `MEM_REQ_WDOG_EN` and `WDOG_CYCLES=8`; store issued with no `dhit` -> `wdog_err` rises after 8 DREQ cycles and stays set after a later `dhit`. Without the macro -> `wdog_err` stays 0.
